// File: rtl/irq_mc_pkg.sv
// irq_mc_pkg: shared FSM states, status codes and one-hot helper for the multi-channel irq handler
package irq_mc_pkg;
  typedef enum logic [2:0] {S_INIT, S_WAIT, S_SERVE, S_RELEASE, S_TMO} state_t;
  localparam logic [1:0] US_RESET = 2'b00;
  localparam logic [1:0] US_NORM  = 2'b01;
  localparam logic [1:0] US_SERV  = 2'b10;
  localparam logic [1:0] US_TMO   = 2'b11;
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction
endpackage

// File: rtl/irq_pick_arb.sv
// irq_pick_arb: combinational fixed-priority / round-robin winner select
module irq_pick_arb #(
  parameter int NCH = 4,
  parameter bit RR_MODE = 1'b1,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  cand,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);
  function automatic logic [IDXW-1:0] pos(input logic [IDXW-1:0] p, input int i);
    return IDXW'(RR_MODE ? (int'(p) + i) % NCH : i);
  endfunction
  // scanning from the far end lets the nearest candidate overwrite the others
  always_comb begin
    valid = |cand;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (cand[pos(rr_ptr, i)]) idx = pos(rr_ptr, i);
  end
endmodule

// File: rtl/irq_handler_mc.sv
// irq_handler_mc: multi-channel interrupt arbiter with four-phase req/ack handshake and service timeout
module irq_handler_mc
  import irq_mc_pkg::*;
#(
  parameter int NCH = 4,
  parameter bit RR_MODE = 1'b1,
  parameter int TMO_CYCLES = 15,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  en,
  input  logic            cont_eql,
  input  logic [NCH-1:0]  err_clr,
  output logic [NCH-1:0]  ack,
  output logic [IDXW-1:0] cc_mux,
  output logic [1:0]      uscite,
  output logic            enable_count,
  output logic            busy,
  output logic [NCH-1:0]  timeout_err
);
  localparam int CW = TMO_CYCLES == 0 ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TMO_CYCLES == 0 ? 0 : TMO_CYCLES - 1);
  state_t state, state_n;
  logic [IDXW-1:0] rr_ptr, win;
  logic [CW-1:0] cnt;
  logic valid, grant, drop, tmo_hit;
  irq_pick_arb #(.NCH(NCH), .RR_MODE(RR_MODE)) u_arb (
    .cand(req & en), .rr_ptr(rr_ptr), .valid(valid), .idx(win)
  );
  // a dropped request wins over a timeout landing on the same cycle
  always_comb begin
    grant = state == S_WAIT && valid;
    drop = (state == S_SERVE || state == S_TMO) && !req[cc_mux];
    tmo_hit = state == S_SERVE && req[cc_mux] && TMO_CYCLES != 0 && cnt == T_LAST;
    state_n = state == S_INIT ? S_WAIT :
              grant ? S_SERVE :
              drop ? S_RELEASE :
              tmo_hit ? S_TMO :
              state == S_RELEASE ? S_WAIT : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      ack <= '0;
      cc_mux <= '0;
      uscite <= US_RESET;
      enable_count <= 1'b0;
      busy <= 1'b0;
      timeout_err <= '0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      enable_count <= state_n == S_SERVE || !cont_eql;
      cnt <= grant ? '0 : state == S_SERVE ? cnt + CW'(!(&cnt)) : cnt;
      timeout_err <= (timeout_err & ~err_clr) | (tmo_hit ? NCH'(onehot(4'(cc_mux))) : '0);
      if (state == S_INIT) uscite <= US_NORM;
      if (grant) begin
        cc_mux <= win;
        ack <= NCH'(onehot(4'(win)));
        uscite <= US_SERV;
        busy <= 1'b1;
      end
      if (drop || tmo_hit) ack <= '0;
      if (tmo_hit) uscite <= US_TMO;
      if (state == S_RELEASE) begin
        rr_ptr <= cc_mux == IDXW'(NCH - 1) ? '0 : cc_mux + 1'b1;
        uscite <= US_NORM;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: doc/irq_handler_mc.md
Name: irq_handler_mc

Overview:
- Multi-channel successor to the single-channel interrupt handshake FSM.
- Accepts NCH level-sensitive interrupt requests and picks one by fixed priority or round-robin.
- Runs a req/ack four-phase handshake with the winning device, with a programmable service timeout.
- Reports status through uscite/cc_mux-style outputs and sits between peripheral request lines and the controller's count/mux logic.

Parameters:
- NCH, 4, number of request channels (2..16).
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- TMO_CYCLES, 15, cycles allowed in SERVE before timeout; 0 disables the timeout.
- IDXW, $clog2(NCH), derived localparam, width of the channel index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NCH  per-channel interrupt request (level).
- en  in  NCH  per-channel enable mask; sampled only at arbitration.
- cont_eql  in  1  counter-equal flag; drives enable_count.
- err_clr  in  NCH  per-channel clear for timeout_err (single-cycle pulse).
- ack  out  NCH  one-hot acknowledge to the granted channel.
- cc_mux  out  IDXW  index of the current or last granted channel.
- uscite  out  2  status: 00 reset, 01 idle/waiting, 10 serving, 11 timeout.
- enable_count  out  1  registered count enable.
- busy  out  1  high in SERVE, RELEASE and TMO.
- timeout_err  out  NCH  sticky per-channel timeout flags.

Behaviour:
- Reset (asynchronous): state=S_INIT; ack=0, cc_mux=0, uscite=00, enable_count=0, busy=0, timeout_err=0; rr_ptr=0, cnt=0. Asserting reset mid-handshake drops ack immediately. No output glitches on deassertion.
- enable_count is updated every non-reset cycle to ~cont_eql. The exception is SERVE, where it is forced to 1.
- S_INIT: uscite<=01, go to S_WAIT. Exactly one cycle after reset release.
- S_WAIT:
  - Candidates are req & en.
  - If none: hold, uscite=01.
  - Otherwise pick the winner:
    - RR_MODE=0: lowest-index candidate.
    - RR_MODE=1: first candidate at or after rr_ptr, wrapping modulo NCH.
  - On a win, in the same edge: cc_mux<=winner, ack<=onehot(winner), uscite<=10, busy<=1, cnt<=0, go to S_SERVE.
  - Latency: req seen at edge k gives ack visible after edge k.
- S_SERVE:
  - Hold ack; cnt increments each cycle, saturating.
  - If req[cc_mux]==0: ack<=0, go to S_RELEASE.
  - Else if TMO_CYCLES!=0 and cnt==TMO_CYCLES-1: ack<=0, uscite<=11, timeout_err[cc_mux]<=1, go to S_TMO.
  - Request deassertion takes precedence over timeout in the same cycle.
  - Clearing en[cc_mux] during service has no effect. Other channels' requests remain pending (they are level-sensitive, not latched).
- S_RELEASE:
  - One cycle; ack stays 0.
  - rr_ptr<=(cc_mux+1) mod NCH, wrapping at NCH-1 to 0.
  - uscite<=01, busy<=0, go to S_WAIT.
  - This guarantees at least one idle cycle between grants.
- S_TMO:
  - ack=0, uscite=11.
  - Wait until req[cc_mux]==0, then go to S_RELEASE, which also advances rr_ptr.
- timeout_err:
  - Bit i is set by a timeout on channel i and cleared by err_clr[i].
  - If set and clear hit the same bit in the same cycle, set wins.
- Invariants:
  - ack is zero- or one-hot.
  - ack is never high outside S_SERVE.
  - cc_mux is stable while busy.
  - cnt width is $clog2(TMO_CYCLES+1), minimum 1.

Decomposition:
- Package irq_mc_pkg holds:
  - state enum {S_INIT, S_WAIT, S_SERVE, S_RELEASE, S_TMO} (3 bits);
  - uscite codes US_RESET=00, US_NORM=01, US_SERV=10, US_TMO=11;
  - the onehot/index helper function.
- One combinational sub-module, irq_pick_arb (params NCH, RR_MODE):
  - inputs cand[NCH], rr_ptr;
  - outputs valid, idx.
- The top holds the FSM, counter, sticky flags and rr_ptr.

Test Plan:
- Reset release, req=0: uscite 00→01 after one clock, ack=0, busy=0. Then assert reset mid-SERVE: ack goes to 0 asynchronously before the next edge.
- NCH=4, RR_MODE=0, req=1010 held, each device dropping its req 2 cycles after ack: channel 1 is granted (ack=0010, cc_mux=1) repeatedly and channel 3 is starved.
- RR_MODE=1, req=1111 held, devices drop req 1 cycle after ack then reassert after RELEASE: grant order 0,1,2,3,0. One RELEASE idle cycle between grants.
- TMO_CYCLES=15, req[2] never drops: ack[2] high for 15 cycles, then uscite=11 and timeout_err=0100. Drop req[2]: RELEASE then WAIT. Pulse err_clr[2]: timeout_err=0000.
- Same-cycle events: req drops on the timeout cycle → RELEASE with no error. err_clr[i] coincident with a new timeout on i → flag stays 1. en[1]=0 with req[1]=1 → channel 1 is never granted.
- cont_eql toggling in WAIT: enable_count follows ~cont_eql one cycle later. In SERVE: enable_count=1 regardless of cont_eql.
